execute: RTL and testbench

- Y86-64 execute stage plus E→M pipeline register. Sits directly downstream of the decode→E register.
- Consumes E-register fields. Computes ALU result, evaluates branch/cmov condition against the condition-code register, and owns CC state.
- Provides same-cycle forwarding outputs (e_valE, e_dstE, e_Cnd) and latches results into the M register.

---
 rtl/execute_pkg.sv | 69 ++++++
 rtl/execute_alu.sv | 42 ++++
 rtl/execute.sv | 164 ++++++++++++++++
 tb/tb_execute.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction, ALU-function and
// status codes, plus the branch/cmov condition evaluator.
package execute_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alufn_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] REG_NONE = 4'hF;

    // cc is packed {ZF,SF,OF}; unknown condition codes never fire.
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf  = cc[2];
        sf  = cc[1];
        of  = cc[0];
        res = 1'b0;
        case (cond_e'(ifun))
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational Y86-64 ALU: B op A modulo 2^DW, with the flag set {ZF,SF,OF}
// the operation would produce.
module execute_alu
    import execute_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [DW-1:0] alu_a_i,
    input  logic [DW-1:0] alu_b_i,
    input  logic [3:0]    alufun_i,
    output logic [DW-1:0] val_e_o,
    output logic [2:0]    flags_o
);

    logic [DW-1:0] res;
    logic          of;

    always_comb begin
        res = '0;
        of  = 1'b0;
        case (alufn_e'(alufun_i))
            ALU_ADD: begin
                res = alu_b_i + alu_a_i;
                of  = (alu_a_i[DW-1] == alu_b_i[DW-1]) && (res[DW-1] != alu_a_i[DW-1]);
            end
            ALU_SUB: begin
                res = alu_b_i - alu_a_i;
                of  = (alu_a_i[DW-1] != alu_b_i[DW-1]) && (res[DW-1] != alu_b_i[DW-1]);
            end
            ALU_AND: res = alu_b_i & alu_a_i;
            ALU_XOR: res = alu_b_i ^ alu_a_i;
            default: begin
                res = '0;
                of  = 1'b0;
            end
        endcase
    end

    assign val_e_o = res;
    assign flags_o = {(res == '0), res[DW-1], of};

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register,
// branch/cmov condition and the E->M pipeline register.
module execute
    import execute_pkg::*;
#(
    parameter int         DW    = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [2:0]    E_stat_i,
    input  logic [63:0]   E_pc_i,
    input  logic [3:0]    E_icode_i,
    input  logic [3:0]    E_ifun_i,
    input  logic [DW-1:0] E_valA_i,
    input  logic [DW-1:0] E_valB_i,
    input  logic [DW-1:0] E_valC_i,
    input  logic [3:0]    E_dstE_i,
    input  logic [3:0]    E_dstM_i,
    input  logic [2:0]    m_stat_i,
    input  logic [2:0]    W_stat_i,
    input  logic          M_stall_i,
    input  logic          M_bubble_i,
    output logic [DW-1:0] e_valE_o,
    output logic [3:0]    e_dstE_o,
    output logic          e_Cnd_o,
    output logic [2:0]    cc_o,
    output logic [2:0]    M_stat_o,
    output logic [63:0]   M_pc_o,
    output logic [3:0]    M_icode_o,
    output logic          M_Cnd_o,
    output logic [DW-1:0] M_valE_o,
    output logic [DW-1:0] M_valA_o,
    output logic [3:0]    M_dstE_o,
    output logic [3:0]    M_dstM_o
);

    localparam logic [DW-1:0] PLUS8  = DW'(8);
    localparam logic [DW-1:0] MINUS8 = ~DW'(7);

    icode_e        icode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alufun;
    logic [DW-1:0] alu_res;
    logic [2:0]    alu_flags;
    logic          cnd;
    logic          set_cc;

    logic [2:0]    cc_q,      cc_d;
    logic [2:0]    m_stat_q,  m_stat_d;
    logic [63:0]   m_pc_q,    m_pc_d;
    logic [3:0]    m_icode_q, m_icode_d;
    logic          m_cnd_q,   m_cnd_d;
    logic [DW-1:0] m_vale_q,  m_vale_d;
    logic [DW-1:0] m_vala_q,  m_vala_d;
    logic [3:0]    m_dste_q,  m_dste_d;
    logic [3:0]    m_dstm_q,  m_dstm_d;

    assign icode = icode_e'(E_icode_i);

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode)
            I_RRMOVQ, I_OPQ:              alu_a = E_valA_i;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC_i;
            I_CALL, I_PUSHQ:              alu_a = MINUS8;
            I_RET, I_POPQ:                alu_a = PLUS8;
            default:                      alu_a = '0;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB_i;
            default:                                                   alu_b = '0;
        endcase
    end

    assign alufun = (icode == I_OPQ) ? E_ifun_i : ALU_ADD;

    execute_alu #(.DW(DW)) u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .alufun_i (alufun),
        .val_e_o  (alu_res),
        .flags_o  (alu_flags)
    );

    // Condition is judged on the pre-update CC so a flag-setting OPQ in E
    // cannot influence its own cycle's branch/cmov decision.
    assign cnd    = ((icode == I_JXX) || (icode == I_RRMOVQ)) ? cond_eval(E_ifun_i, cc_q) : 1'b0;
    assign set_cc = (icode == I_OPQ) && (E_stat_i == STAT_AOK) && (m_stat_i == STAT_AOK)
                 && (W_stat_i == STAT_AOK) && !M_stall_i;

    assign e_valE_o = alu_res;
    assign e_Cnd_o  = cnd;
    assign e_dstE_o = ((icode == I_RRMOVQ) && !cnd) ? RNONE : E_dstE_i;

    assign cc_d = set_cc ? alu_flags : cc_q;

    always_comb begin
        m_stat_d  = m_stat_q;
        m_pc_d    = m_pc_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_vale_d  = m_vale_q;
        m_vala_d  = m_vala_q;
        m_dste_d  = m_dste_q;
        m_dstm_d  = m_dstm_q;
        if (M_bubble_i) begin
            m_stat_d  = STAT_AOK;
            m_pc_d    = '0;
            m_icode_d = I_NOP;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = RNONE;
            m_dstm_d  = RNONE;
        end else if (!M_stall_i) begin
            m_stat_d  = E_stat_i;
            m_pc_d    = E_pc_i;
            m_icode_d = E_icode_i;
            m_cnd_d   = cnd;
            m_vale_d  = alu_res;
            m_vala_d  = E_valA_i;
            m_dste_d  = e_dstE_o;
            m_dstm_d  = E_dstM_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cc_q      <= 3'b100;
            m_stat_q  <= STAT_AOK;
            m_pc_q    <= '0;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            cc_q      <= cc_d;
            m_stat_q  <= m_stat_d;
            m_pc_q    <= m_pc_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign cc_o      = cc_q;
    assign M_stat_o  = m_stat_q;
    assign M_pc_o    = m_pc_q;
    assign M_icode_o = m_icode_q;
    assign M_Cnd_o   = m_cnd_q;
    assign M_valE_o  = m_vale_q;
    assign M_valA_o  = m_vala_q;
    assign M_dstE_o  = m_dste_q;
    assign M_dstM_o  = m_dstm_q;

endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: combinational e_* checked in-cycle, expected
// M-register/CC state queued per cycle and compared by a separate monitor.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  E_stat;
    logic [63:0] E_pc;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [3:0]  E_dstE, E_dstM;
    logic [2:0]  m_stat, W_stat;
    logic        M_stall, M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  cc;
    logic [2:0]  M_stat;
    logic [63:0] M_pc;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;

    always #5 clk = ~clk;

    execute dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .E_stat_i   (E_stat),
        .E_pc_i     (E_pc),
        .E_icode_i  (E_icode),
        .E_ifun_i   (E_ifun),
        .E_valA_i   (E_valA),
        .E_valB_i   (E_valB),
        .E_valC_i   (E_valC),
        .E_dstE_i   (E_dstE),
        .E_dstM_i   (E_dstM),
        .m_stat_i   (m_stat),
        .W_stat_i   (W_stat),
        .M_stall_i  (M_stall),
        .M_bubble_i (M_bubble),
        .e_valE_o   (e_valE),
        .e_dstE_o   (e_dstE),
        .e_Cnd_o    (e_Cnd),
        .cc_o       (cc),
        .M_stat_o   (M_stat),
        .M_pc_o     (M_pc),
        .M_icode_o  (M_icode),
        .M_Cnd_o    (M_Cnd),
        .M_valE_o   (M_valE),
        .M_valA_o   (M_valA),
        .M_dstE_o   (M_dstE),
        .M_dstM_o   (M_dstM)
    );

    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [2:0]  cc;
    } exp_t;

    localparam logic [3:0] NOP = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3, MRMOVQ = 4'h5,
                           OPQ = 4'h6, JXX = 4'h7, PUSHQ = 4'hA, POPQ = 4'hB;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XOR = 4'h3;
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3;
    localparam logic [3:0] RN = 4'hF;

    exp_t        sb_q[$];
    exp_t        last_m;
    int          total = 0;
    int          bad   = 0;
    int          vec   = 0;
    logic [63:0] pc_ctr = 64'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step(input string name, input logic rstn, input logic stall, input logic bubble,
                        input logic [2:0] mst, input logic [2:0] wst,
                        input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] dste, input logic [3:0] dstm,
                        input logic [63:0] x_vale, input logic [3:0] x_dste, input logic x_cnd,
                        input logic [2:0] x_cc);
        exp_t e;
        @(negedge clk);
        vec++;
        pc_ctr   = pc_ctr + 64'd10;
        rst_n    = rstn;
        M_stall  = stall;
        M_bubble = bubble;
        m_stat   = mst;
        W_stat   = wst;
        E_stat   = AOK;
        E_pc     = pc_ctr;
        E_icode  = icode;
        E_ifun   = ifun;
        E_valA   = va;
        E_valB   = vb;
        E_valC   = vc;
        E_dstE   = dste;
        E_dstM   = dstm;
        #1;
        chk({name, ".e_valE"}, e_valE, x_vale);
        chk({name, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, x_dste});
        chk({name, ".e_Cnd"}, {63'd0, e_Cnd}, {63'd0, x_cnd});
        if (!rstn || bubble) begin
            e = '{stat: AOK, pc: 64'd0, icode: NOP, cnd: 1'b0, vale: 64'd0, vala: 64'd0,
                  dste: RN, dstm: RN, cc: 3'b000};
        end else if (stall) begin
            e = last_m;
        end else begin
            e = '{stat: AOK, pc: pc_ctr, icode: icode, cnd: x_cnd, vale: x_vale, vala: va,
                  dste: x_dste, dstm: dstm, cc: 3'b000};
        end
        last_m = e;
        e.cc   = x_cc;
        sb_q.push_back(e);
        $display("vec %0d %s: icode=%0h ifun=%0h e_valE=0x%0h e_dstE=%0h e_Cnd=%0b",
                 vec, name, icode, ifun, e_valE, e_dstE, e_Cnd);
    endtask

    // Monitor: M register and CC are the registered outputs, one per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("M_stat",  {61'd0, M_stat},  {61'd0, e.stat});
                chk("M_pc",    M_pc,             e.pc);
                chk("M_icode", {60'd0, M_icode}, {60'd0, e.icode});
                chk("M_Cnd",   {63'd0, M_Cnd},   {63'd0, e.cnd});
                chk("M_valE",  M_valE,           e.vale);
                chk("M_valA",  M_valA,           e.vala);
                chk("M_dstE",  {60'd0, M_dstE},  {60'd0, e.dste});
                chk("M_dstM",  {60'd0, M_dstM},  {60'd0, e.dstm});
                chk("cc",      {61'd0, cc},      {61'd0, e.cc});
            end
        end
    end

    initial begin
        rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; m_stat = AOK; W_stat = AOK;
        E_stat = AOK; E_pc = '0; E_icode = NOP; E_ifun = '0;
        E_valA = '0; E_valB = '0; E_valC = '0; E_dstE = RN; E_dstM = RN;

        //    name        rstn st bu mst  wst  icode   ifun va                      vb     vc      dstE  dstM  x_valE                  x_dstE x_cnd x_cc
        step("reset",     0,  0, 0, AOK, AOK, NOP,    0,   64'd0,                  64'd0, 64'd0,  RN,   RN,   64'd0,                  RN,    0, 3'b100);
        step("sub_eq",    1,  0, 0, AOK, AOK, OPQ,    SUB, 64'd5,                  64'd5, 64'd0,  4'd2, RN,   64'd0,                  4'd2,  0, 3'b100);
        step("add_ovf",   1,  0, 0, AOK, AOK, OPQ,    ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd2, RN,   64'h8000_0000_0000_0000, 4'd2, 0, 3'b011);
        step("add_pos",   1,  0, 0, AOK, AOK, OPQ,    ADD, 64'd1,                  64'd1, 64'd0,  4'd2, RN,   64'd2,                  4'd2,  0, 3'b000);
        step("cmovl_nt",  1,  0, 0, AOK, AOK, RRMOVQ, 4'd2, 64'h55,                64'h99, 64'd0, 4'd3, RN,   64'h55,                 RN,    0, 3'b000);
        step("sub_neg",   1,  0, 0, AOK, AOK, OPQ,    SUB, 64'd5,                  64'd3, 64'd0,  4'd2, RN,   64'hFFFF_FFFF_FFFF_FFFE, 4'd2, 0, 3'b010);
        step("cmovl_t",   1,  0, 0, AOK, AOK, RRMOVQ, 4'd2, 64'h55,                64'h99, 64'd0, 4'd3, RN,   64'h55,                 4'd3,  1, 3'b010);
        step("pushq",     1,  0, 0, AOK, AOK, PUSHQ,  0,   64'h1234,               64'h100, 64'd0, 4'd4, RN,  64'hF8,                 4'd4,  0, 3'b010);
        step("popq",      1,  0, 0, AOK, AOK, POPQ,   0,   64'h100,                64'h100, 64'd0, 4'd4, 4'd7, 64'h108,               4'd4,  0, 3'b010);
        step("mrmovq",    1,  0, 0, AOK, AOK, MRMOVQ, 0,   64'd0,                  64'h20, 64'd8, RN,   4'd5, 64'h28,                 RN,    0, 3'b010);
        step("jl_taken",  1,  0, 0, AOK, AOK, JXX,    4'd2, 64'd0,                 64'd0, 64'h400, RN,  RN,   64'd0,                  RN,    1, 3'b010);
        step("jg_not",    1,  0, 0, AOK, AOK, JXX,    4'd6, 64'd0,                 64'd0, 64'h400, RN,  RN,   64'd0,                  RN,    0, 3'b010);
        step("xor_madr",  1,  0, 0, ADR, AOK, OPQ,    XOR, 64'hF0,                 64'hF0, 64'd0, 4'd2, RN,   64'd0,                  4'd2,  0, 3'b010);
        step("xor_whlt",  1,  0, 0, AOK, HLT, OPQ,    XOR, 64'hF0,                 64'h0F, 64'd0, 4'd2, RN,   64'hFF,                 4'd2,  0, 3'b010);
        step("opq_bad",   1,  0, 0, AOK, AOK, OPQ,    4'd5, 64'd3,                 64'd4, 64'd0,  4'd2, RN,   64'd0,                  4'd2,  0, 3'b100);
        step("stall1",    1,  1, 0, AOK, AOK, OPQ,    ADD, 64'd1,                  64'd2, 64'd0,  4'd2, RN,   64'd3,                  4'd2,  0, 3'b100);
        step("stall2",    1,  1, 0, AOK, AOK, IRMOVQ, 0,   64'd0,                  64'd0, 64'h77, 4'd6, RN,   64'h77,                 4'd6,  0, 3'b100);
        step("bubble",    1,  1, 1, AOK, AOK, IRMOVQ, 0,   64'd0,                  64'd0, 64'h88, 4'd6, RN,   64'h88,                 4'd6,  0, 3'b100);
        step("add_small", 1,  0, 0, AOK, AOK, OPQ,    ADD, 64'd1,                  64'd2, 64'd0,  4'd2, RN,   64'd3,                  4'd2,  0, 3'b000);
        step("mid_rst",   0,  0, 0, AOK, AOK, OPQ,    SUB, 64'd1,                  64'd1, 64'd0,  4'd2, RN,   64'd0,                  4'd2,  0, 3'b100);
        step("post_rst",  1,  0, 0, AOK, AOK, NOP,    0,   64'd0,                  64'd0, 64'd0,  RN,   RN,   64'd0,                  RN,    0, 3'b100);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
